// File: rtl/alu_ex_stage_if.sv
// ---------------------------------------------------------------------------
// alu_ex_stage_if
//
// Interface for the toyMIPS execute stage. It carries both handshakes and
// their payloads in one bundle.
//
//   Upstream side (decode -> execute):
//     in_valid  : upstream presents an operation
//     in_ready  : execute stage can accept it (registered in the stage)
//     op        : 3-bit ALU operation code
//     din1/din2 : operands A and B, WIDTH bits, two's complement
//
//   Downstream side (execute -> writeback):
//     out_valid : result present
//     out_ready : writeback takes the result
//     dout      : result, WIDTH bits
//     overflow  : signed overflow of add/sub, 0 for every other op
//     zero      : dout == 0
//
// Modports:
//   master : the environment that drives operations and consumes results
//   slave  : the execute stage itself
// ---------------------------------------------------------------------------
interface alu_ex_stage_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid,
    output op,
    output din1,
    output din2,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  dout,
    input  overflow,
    input  zero
  );

  modport slave (
    input  in_valid,
    input  op,
    input  din1,
    input  din2,
    input  out_ready,
    output in_ready,
    output out_valid,
    output dout,
    output overflow,
    output zero
  );

endinterface

// File: rtl/alu_ex_stage.sv
// ---------------------------------------------------------------------------
// alu_ex_stage
//
// Registered execute stage of the toyMIPS datapath. Operations are accepted
// over a valid/ready handshake and computed in a single combinational ALU.
// Each result is then captured into a two-entry skid buffer: an output
// register plus one skid register. Because of the skid entry, in_ready can
// be a pure register, and no bubbles appear when downstream stalls.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_ex_stage_if.slave
//           (in_valid/in_ready/op/din1/din2 upstream,
//            out_valid/out_ready/dout/overflow/zero downstream)
//
// Parameters:
//   WIDTH : operand and result width in bits
//
// Op encoding:
//   000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 slt,
//   111 sltu (only when ALU_EX_SLTU_EN is defined; otherwise the result
//   is 0 and the handshake still completes normally)
//
// Build option:
//   ALU_EX_SLTU_EN : enables unsigned set-less-than on op 111
// ---------------------------------------------------------------------------
module alu_ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_ex_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_SLTU = 3'b111;

  state_t           state;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             out_zero;
  logic [WIDTH-1:0] skid_data;
  logic             skid_ovf;
  logic             skid_zero;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt_bit;
  logic [WIDTH-1:0] alu_data;
  logic             alu_ovf;
  logic             alu_zero;

  logic             accept;
  logic             drain;

  assign opa = bus.din1;
  assign opb = bus.din2;

  // The adder result keeps only WIDTH bits. The carry-out is discarded.
  assign sum = opa + opb;

  // Subtraction is A + ~B + 1. The carry-out of that sum is needed only
  // for the unsigned compare: carry-out == 0 means A < B unsigned.
`ifdef ALU_EX_SLTU_EN
  logic [WIDTH:0] diff_ext;
  logic           borrow;

  assign diff_ext = {1'b0, opa} + {1'b0, ~opb} + (WIDTH+1)'(1);
  assign diff     = diff_ext[WIDTH-1:0];
  assign borrow   = ~diff_ext[WIDTH];
`else
  assign diff = opa + ~opb + WIDTH'(1);
`endif

  // Signed overflow happens when the result sign cannot be right for the
  // operand signs.
  assign add_ovf = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1]  != opa[WIDTH-1]);
  assign sub_ovf = (opa[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);

  // Correcting the difference sign with the overflow bit makes the signed
  // compare exact, even when A - B wraps around.
  assign slt_bit = diff[WIDTH-1] ^ sub_ovf;

  // Combinational ALU. Its result goes into whichever buffer entry takes
  // the accepted operation on this edge.
  always_comb begin
    alu_data = '0;
    alu_ovf  = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_data = sum;
        alu_ovf  = add_ovf;
      end
      OP_SUB: begin
        alu_data = diff;
        alu_ovf  = sub_ovf;
      end
      OP_AND:  alu_data = opa & opb;
      OP_OR:   alu_data = opa | opb;
      OP_XOR:  alu_data = opa ^ opb;
      OP_NOR:  alu_data = ~(opa | opb);
      OP_SLT:  alu_data = {{(WIDTH-1){1'b0}}, slt_bit};
`ifdef ALU_EX_SLTU_EN
      OP_SLTU: alu_data = {{(WIDTH-1){1'b0}}, borrow};
`else
      OP_SLTU: alu_data = '0;
`endif
      default: alu_data = '0;
    endcase
    alu_zero = (alu_data == '0);
  end

  assign accept = bus.in_valid && in_ready_r;
  assign drain  = out_valid_r && bus.out_ready;

  // Skid-buffer control and storage.
  // EMPTY: nothing is held.
  // ONE:   the output register is full.
  // TWO:   the output register and the skid register are both full.
  // in_ready is registered as "next state is not TWO". It stays 0 in reset
  // and rises on the first edge after reset is released.
  // In state ONE, a new result goes to the skid register only when the
  // output register is not draining on the same edge. Otherwise it goes
  // straight to the output register. This keeps acceptance order and
  // adds no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data    <= '0;
      out_ovf     <= 1'b0;
      out_zero    <= 1'b0;
      skid_data   <= '0;
      skid_ovf    <= 1'b0;
      skid_zero   <= 1'b0;
    end else begin
      in_ready_r <= 1'b1;
      case (state)
        EMPTY: begin
          if (accept) begin
            out_data    <= alu_data;
            out_ovf     <= alu_ovf;
            out_zero    <= alu_zero;
            out_valid_r <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            skid_data  <= alu_data;
            skid_ovf   <= alu_ovf;
            skid_zero  <= alu_zero;
            in_ready_r <= 1'b0;
            state      <= TWO;
          end else if (accept && drain) begin
            out_data <= alu_data;
            out_ovf  <= alu_ovf;
            out_zero <= alu_zero;
          end else if (drain) begin
            out_valid_r <= 1'b0;
            state       <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            out_data <= skid_data;
            out_ovf  <= skid_ovf;
            out_zero <= skid_zero;
            state    <= ONE;
          end else begin
            in_ready_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state       <= EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.dout      = out_data;
  assign bus.overflow  = out_ovf;
  assign bus.zero      = out_zero;

endmodule

// File: tb/tb_alu_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_ex_stage
//
// Self-checking bench for alu_ex_stage (WIDTH = 32).
//
// The reference model computes each result with plain integer arithmetic
// on 64-bit signed values. It keeps results in flight in a FIFO queue, in
// acceptance order. Inputs are driven on the falling edge. Outputs are
// compared on the falling edge against the model and against fixed
// expected values.
//
// Build option:
//   ALU_EX_SLTU_EN : when defined, op 111 is checked as unsigned
//                    less-than; otherwise it is checked as a zero result
// ---------------------------------------------------------------------------
module tb_alu_ex_stage;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] d;
    logic         ov;
    logic         z;
  } res_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  res_t q[$];
  logic ready_armed;

  alu_ex_stage_if #(.WIDTH(W)) bus ();

  alu_ex_stage #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference result from arithmetic on sign-extended values.
  function automatic res_t ref_alu(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t   r;
    longint sa;
    longint sb;
    longint s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.d  = '0;
    r.ov = 1'b0;
    case (o)
      3'd0: begin
        s = sa + sb;
        r.d  = W'(s);
        r.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        s = sa - sb;
        r.d  = W'(s);
        r.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: r.d = a & b;
      3'd3: r.d = a | b;
      3'd4: r.d = a ^ b;
      3'd5: r.d = ~(a | b);
      3'd6: r.d = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_EX_SLTU_EN
      3'd7: r.d = (a < b) ? 32'd1 : 32'd0;
`else
      3'd7: r.d = '0;
`endif
      default: r.d = '0;
    endcase
    r.z = (r.d == '0);
    return r;
  endfunction

  task automatic checkWord(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic ordy);
    bus.in_valid  = v;
    bus.op        = o;
    bus.din1      = a;
    bus.din2      = b;
    bus.out_ready = ordy;
  endtask

  // Compares the DUT against the model's in-flight queue.
  task automatic checkOutput();
    checkBit("out_valid", bus.out_valid, q.size() > 0);
    checkBit("in_ready", bus.in_ready, ready_armed && (q.size() < 2));
    if (q.size() > 0) begin
      checkWord("dout", bus.dout, q[0].d);
      checkBit("overflow", bus.overflow, q[0].ov);
      checkBit("zero", bus.zero, q[0].z);
    end
  endtask

  // One full clock: drive, check, update the model, advance to the next falling edge.
  task automatic cycle(input logic v, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ordy);
    logic acc;
    logic drn;
    applyStimulus(v, o, a, b, ordy);
    checkOutput();
    acc = v && ready_armed && (q.size() < 2);
    drn = (q.size() > 0) && ordy;
    if (drn) void'(q.pop_front());
    if (acc) q.push_back(ref_alu(o, a, b));
    @(posedge clk);
    ready_armed = 1'b1;
    @(negedge clk);
  endtask

  task automatic expectOut(input string tag, input logic [W-1:0] d, input logic ov, input logic z);
    checkBit({tag, "_valid"}, bus.out_valid, 1'b1);
    checkWord({tag, "_dout"}, bus.dout, d);
    checkBit({tag, "_ovf"}, bus.overflow, ov);
    checkBit({tag, "_zero"}, bus.zero, z);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    checks      = 0;
    failures    = 0;
    ready_armed = 1'b0;
    rst_n       = 1'b0;
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b0);

    // Reset state
    @(negedge clk);
    checkBit("rst_out_valid", bus.out_valid, 1'b0);
    checkBit("rst_in_ready", bus.in_ready, 1'b0);
    checkWord("rst_dout", bus.dout, 32'h0);
    checkBit("rst_overflow", bus.overflow, 1'b0);
    checkBit("rst_zero", bus.zero, 1'b0);
    rst_n = 1'b1;
    #1;
    checkBit("rel_in_ready_before_edge", bus.in_ready, 1'b0);
    cycle(1'b0, 3'd0, '0, '0, 1'b1);
    checkBit("rel_in_ready_after_edge", bus.in_ready, 1'b1);

    // Basic arithmetic and signed compare
    cycle(1'b1, 3'd0, 32'h0000_0005, 32'h0000_0003, 1'b1);
    expectOut("add_5_3", 32'h0000_0008, 1'b0, 1'b0);
    cycle(1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    expectOut("slt_m1_1", 32'h0000_0001, 1'b0, 1'b0);
    cycle(1'b1, 3'd6, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    expectOut("slt_max_min", 32'h0000_0000, 1'b0, 1'b1);
    cycle(1'b1, 3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    expectOut("add_ovf", 32'h8000_0000, 1'b1, 1'b0);
    cycle(1'b1, 3'd1, 32'h1234_5678, 32'h1234_5678, 1'b1);
    expectOut("sub_eq", 32'h0000_0000, 1'b0, 1'b1);
    cycle(1'b1, 3'd1, 32'h8000_0000, 32'h0000_0001, 1'b1);
    expectOut("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b0);
    cycle(1'b1, 3'd5, 32'h0F0F_0000, 32'h00F0_00FF, 1'b1);
    expectOut("nor", 32'hF000_FF00, 1'b0, 1'b0);

`ifdef ALU_EX_SLTU_EN
    cycle(1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    expectOut("sltu_big_small", 32'h0000_0000, 1'b0, 1'b1);
    cycle(1'b1, 3'd7, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
    expectOut("sltu_small_big", 32'h0000_0001, 1'b0, 1'b0);
`else
    cycle(1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    expectOut("op7_unsupported", 32'h0000_0000, 1'b0, 1'b1);
`endif
    cycle(1'b0, 3'd0, '0, '0, 1'b1);
    checkBit("idle_out_valid", bus.out_valid, 1'b0);

    // Backpressure: two results fill the buffer, the third operation waits
    cycle(1'b1, 3'd0, 32'd1, 32'd1, 1'b0);
    expectOut("bp_first", 32'd2, 1'b0, 1'b0);
    cycle(1'b1, 3'd0, 32'd2, 32'd2, 1'b0);
    checkBit("bp_full_in_ready", bus.in_ready, 1'b0);
    expectOut("bp_hold1", 32'd2, 1'b0, 1'b0);
    cycle(1'b1, 3'd0, 32'd3, 32'd3, 1'b0);
    expectOut("bp_hold2", 32'd2, 1'b0, 1'b0);
    cycle(1'b1, 3'd0, 32'd3, 32'd3, 1'b1);
    expectOut("bp_second", 32'd4, 1'b0, 1'b0);
    checkBit("bp_ready_again", bus.in_ready, 1'b1);
    cycle(1'b1, 3'd0, 32'd3, 32'd3, 1'b1);
    expectOut("bp_third", 32'd6, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, '0, '0, 1'b1);
    checkBit("bp_no_duplicate", bus.out_valid, 1'b0);

    // Reset in the middle of a full buffer
    cycle(1'b1, 3'd0, 32'd10, 32'd10, 1'b0);
    cycle(1'b1, 3'd0, 32'd20, 32'd20, 1'b0);
    checkBit("mid_full_in_ready", bus.in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    checkBit("mid_rst_out_valid", bus.out_valid, 1'b0);
    checkBit("mid_rst_in_ready", bus.in_ready, 1'b0);
    checkWord("mid_rst_dout", bus.dout, 32'h0);
    #1;
    rst_n = 1'b1;
    q.delete();
    ready_armed = 1'b0;
    cycle(1'b0, 3'd0, '0, '0, 1'b1);
    checkBit("mid_rel_in_ready", bus.in_ready, 1'b1);
    cycle(1'b0, 3'd0, '0, '0, 1'b1);
    cycle(1'b0, 3'd0, '0, '0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
            $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 3'd0, '0, '0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Registered execute stage of the toyMIPS datapath; sits between operand fetch/decode and writeback.
- Accepts two operands plus a 3-bit ALU op over a valid/ready handshake.
- Computes add/sub/logic/set-less-than and presents the registered result downstream.
- Contains a 2-entry skid buffer (output register plus skid register), so upstream ready is fully registered and there are no bubbles under backpressure.

Parameters:
WIDTH, 32, operand/result width in bits (two's complement)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream has an operation
in_ready  output  1  stage can accept; registered
op  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 slt, 111 sltu (see Optional Feature)
din1  input  WIDTH  operand A
din2  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
dout  output  WIDTH  result
overflow  output  1  signed overflow of add/sub; 0 for all other ops
zero  output  1  dout == 0

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on rst_n. Clock and reset ports are named clk and rst_n.
- Reset values (asserted immediately):
  - out_valid=0, dout=0, overflow=0, zero=0, skid empty.
  - in_ready=0; rises to 1 on the first clk edge after rst_n deasserts.
- Handshakes:
  - Input transfer occurs on a clk edge where in_valid&&in_ready.
  - Output transfer occurs on a clk edge where out_valid&&out_ready.
  - Upstream may change inputs freely while in_valid=0.
- Arithmetic (WIDTH-bit, carry-out discarded):
  - add: A+B.
  - sub: A+(~B)+1.
  - overflow for add: A and B signs equal, and result sign differs.
  - overflow for sub: A and B signs differ, and result sign differs from A.
  - slt: dout = {WIDTH-1 zeros, lt}, with lt = diff[WIDTH-1] XOR sub_overflow. This is signed compare, correct at all extremes.
  - Logic ops are bitwise.
  - zero is computed on the final dout of every op.
- Latency: 1 cycle. A result accepted at edge N is visible at out_valid/dout after edge N when the output register is empty or draining.
- Buffer states: EMPTY, ONE (output register full), TWO (output + skid full).
  - EMPTY: accept -> ONE.
  - ONE:
    - accept && !drain -> TWO (new result to skid).
    - accept && drain -> ONE (new result to output register).
    - drain only -> EMPTY.
  - TWO:
    - in_ready=0.
    - drain -> ONE; skid moves to the output register on that edge.
- in_ready next = (next state != TWO).
- Ordering: results leave strictly in acceptance order.
- Output stability: dout/overflow/zero are held stable while out_valid && !out_ready.
- Reset mid-operation: all buffered results are discarded and nothing is emitted after release until a new input is accepted.

Optional Feature:
- Macro: ALU_EX_SLTU_EN.
- Defined: op 111 = unsigned less-than, lt = borrow of A-B (carry-out of A+~B+1 == 0); overflow=0.
- Undefined: op 111 is unsupported, gives dout=0, overflow=0, zero=1, and still completes the handshake normally.

Test Plan:
- Reset release, then op=000, A=0x00000005, B=0x00000003, out_ready=1 -> one cycle later out_valid=1, dout=0x00000008, overflow=0, zero=0.
- op=110, A=0xFFFFFFFF, B=0x00000001 -> dout=1. Then A=0x7FFFFFFF, B=0x80000000 -> dout=0 (internal sub overflows, compare still correct).
- op=000, A=0x7FFFFFFF, B=0x00000001 -> dout=0x80000000, overflow=1. Then op=001, A=B=0x12345678 -> dout=0, zero=1, overflow=0.
- Backpressure: out_ready=0, stream three ops (add 1+1, add 2+2, add 3+3) -> first two accepted, in_ready=0 after second accept. Raise out_ready -> outputs 2, 4, 6 in order, no duplicates, dout stable while stalled.
- Reset mid-stream: buffer in state TWO, pulse rst_n low between edges -> out_valid/in_ready drop immediately; after release no stale results, and in_ready=1 after first edge.
- op=111, A=0xFFFFFFFF, B=0x00000001:
  - with ALU_EX_SLTU_EN -> dout=0.
  - with A=0x00000001, B=0xFFFFFFFF -> dout=1.
  - without the macro -> dout=0, zero=1.
